univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//   Parametrised universal shift register; successor to the fixed 4-bit shift_reg.
//   Adds WIDTH generalisation, clock enable, per-cycle mode select (shift L/R, rotate,
//   parallel load, clear) and an autonomous serializer burst with start/busy/done handshake.
//   Sits between parallel datapath registers and single-bit serial links/stimulus benches.
// PARAMETERS
//   WIDTH      8   register width in bits (>=2)
//   MSB_FIRST  1   1: burst shifts left, ser_out taps MSB; 0: burst shifts right, taps LSB
//   CNT_W      $clog2(WIDTH)  burst counter width (derived; do not override)
// PORTS
//   clock    input   1      rising-edge clock
//   reset_n  input   1      asynchronous active-low reset
//   enable   input   1      clock enable for mode ops and burst shifts
//   mode     input   3      op select (see BEHAVIOUR), sampled when enable=1 in IDLE
//   ser_in   input   1      serial fill bit for shifts
//   par_in   input   WIDTH  parallel load data (mode LOAD and burst start)
//   start    input   1      burst request, single-cycle pulse, sampled in IDLE
//   reg_out  output  WIDTH  register contents
//   ser_out  output  1      MSB_FIRST ? reg_out[WIDTH-1] : reg_out[0] (combinational tap)
//   busy     output  1      high while burst in SHIFT state
//   done     output  1      one-cycle pulse at burst completion
// BEHAVIOUR
//   Reset (reset_n=0, async): reg_out=0, busy=0, done=0, ser_out=0, counter=0, state=IDLE.
//     Reset mid-burst aborts immediately; no done pulse.
//   FSM states: IDLE, SHIFT, DONE. busy = (state==SHIFT); done = (state==DONE).
//   IDLE, start=1 (enable ignored): next edge reg<=par_in, cnt<=WIDTH-1, ->SHIFT. start beats mode.
//   IDLE, start=0, enable=1, mode:
//     000 HOLD   reg unchanged
//     001 SHL    reg<={reg[WIDTH-2:0],ser_in}
//     010 SHR    reg<={ser_in,reg[WIDTH-1:1]}
//     011 ROL    reg<={reg[WIDTH-2:0],reg[WIDTH-1]}
//     100 ROR    reg<={reg[0],reg[WIDTH-1:1]}
//     101 LOAD   reg<=par_in
//     110 RSVD   treated as HOLD
//     111 CLEAR  reg<=0
//   IDLE, enable=0: reg holds.
//   SHIFT: each enable=1 edge shifts one bit (SHL if MSB_FIRST else SHR, fill ser_in);
//     cnt>0: cnt<=cnt-1, stay; cnt==0: shift, ->DONE. enable=0 stalls (no shift, cnt held).
//     WIDTH bits presented on ser_out, first bit visible in cycle after load.
//     start and mode ignored while busy.
//   DONE: one cycle, reg holds, ->IDLE unconditionally; start in DONE ignored.
//   Latency: mode op 1 cycle; burst = 1 load + WIDTH enabled shifts + 1 DONE cycle.
//   No arithmetic beyond counter decrement; counter never wraps (exit at 0).
// TESTING (WIDTH=8 unless stated)
//   1 reset: reset_n=0 mid-operation -> reg_out=8'h00, busy=0, done=0 same cycle, no clock needed.
//   2 modes: LOAD 8'h81; SHL ser_in=0 -> 8'h02; ROR -> 8'h01; ROL -> 8'h02; SHR ser_in=1 -> 8'h81; CLEAR -> 8'h00.
//   3 burst MSB_FIRST=1, enable=1, par_in=8'hA5: ser_out 1,0,1,0,0,1,0,1 over 8 busy cycles, done
//     pulse next cycle, reg_out=8'h00 with ser_in=0; total start->done 10 edges.
//   4 stall: repeat 3, drop enable 3 cycles mid-burst -> sequence unchanged, busy stretched 3 cycles.
//   5 interlock: start+mode=LOAD in IDLE -> burst wins; start/mode during busy and DONE -> ignored.
//   6 MSB_FIRST=0, WIDTH=4, par_in=4'hB -> ser_out 1,1,0,1 (LSB first); reset mid-burst -> no done.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: per-cycle shift/rotate/load/clear ops plus an
// autonomous WIDTH-bit serializer burst with start/busy/done handshake.
module univ_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CNT_W    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  output logic [WIDTH-1:0] reg_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_ROL   = 3'b011;
  localparam logic [2:0] MODE_ROR   = 3'b100;
  localparam logic [2:0] MODE_LOAD  = 3'b101;
  localparam logic [2:0] MODE_RSVD  = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] reg_r;
  logic [WIDTH-1:0] reg_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             busy_r;
  logic             done_r;

  function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] r, input logic fill);
    shift_left = {r[WIDTH-2:0], fill};
  endfunction

  function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] r, input logic fill);
    shift_right = {fill, r[WIDTH-1:1]};
  endfunction

  // Next-state, next-register and next-counter selection
  always_comb begin
    state_nxt_s = state_r;
    reg_nxt_s   = reg_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          reg_nxt_s   = par_in;
          cnt_nxt_s   = CNT_LAST;
          state_nxt_s = ST_SHIFT;
        end else if (enable) begin
          case (mode)
            MODE_HOLD:  reg_nxt_s = reg_r;
            MODE_SHL:   reg_nxt_s = shift_left(reg_r, ser_in);
            MODE_SHR:   reg_nxt_s = shift_right(reg_r, ser_in);
            MODE_ROL:   reg_nxt_s = shift_left(reg_r, reg_r[WIDTH-1]);
            MODE_ROR:   reg_nxt_s = shift_right(reg_r, reg_r[0]);
            MODE_LOAD:  reg_nxt_s = par_in;
            MODE_RSVD:  reg_nxt_s = reg_r;
            MODE_CLEAR: reg_nxt_s = {WIDTH{1'b0}};
            default:    reg_nxt_s = reg_r;
          endcase
        end else begin
          reg_nxt_s = reg_r;
        end
      end
      ST_SHIFT: begin
        if (enable) begin
          reg_nxt_s = MSB_FIRST ? shift_left(reg_r, ser_in) : shift_right(reg_r, ser_in);
          // Exit on zero rather than wrapping the counter
          if (cnt_r == CNT_ZERO) begin
            state_nxt_s = ST_DONE;
          end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end
        end else begin
          reg_nxt_s = reg_r;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, data, counter and handshake flag registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      reg_r   <= {WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      reg_r   <= reg_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s == ST_SHIFT);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  assign reg_out = reg_r;
  assign ser_out = MSB_FIRST ? reg_r[WIDTH-1] : reg_r[0];
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Randomized self-checking bench for univ_shift_reg: an 8-bit MSB-first
// instance and a 4-bit LSB-first instance checked against a behavioural model.
module tb_univ_shift_reg;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;

  logic       enable = 1'b0;
  logic [2:0] mode = 3'b000;
  logic       ser_in = 1'b0;
  logic [7:0] par_in = 8'h00;
  logic       start = 1'b0;
  logic [7:0] reg_out;
  logic       ser_out, busy, done;

  logic       enable4 = 1'b0;
  logic [2:0] mode4 = 3'b000;
  logic       ser_in4 = 1'b0;
  logic [3:0] par_in4 = 4'h0;
  logic       start4 = 1'b0;
  logic [3:0] reg_out4;
  logic       ser_out4, busy4, done4;

  int total = 0;
  int bad = 0;

  univ_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode), .ser_in(ser_in),
    .par_in(par_in), .start(start), .reg_out(reg_out), .ser_out(ser_out),
    .busy(busy), .done(done)
  );

  univ_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
    .clock(clock), .reset_n(reset_n), .enable(enable4), .mode(mode4), .ser_in(ser_in4),
    .par_in(par_in4), .start(start4), .reg_out(reg_out4), .ser_out(ser_out4),
    .busy(busy4), .done(done4)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference for an IDLE-state mode op on an 8-bit register, in arithmetic form
  function automatic logic [7:0] model_op(input logic [7:0] r, input logic [2:0] m,
                                          input logic s, input logic [7:0] p);
    int v;
    v = int'(r);
    case (m)
      3'd1: v = (v * 2 + int'(s)) % 256;
      3'd2: v = v / 2 + int'(s) * 128;
      3'd3: v = (v * 2) % 256 + v / 128;
      3'd4: v = v / 2 + (v % 2) * 128;
      3'd5: v = int'(p);
      3'd7: v = 0;
      default: v = int'(r);
    endcase
    return 8'(v);
  endfunction

  task automatic test_reset();
    reset_n = 1'b1;
    enable = 1'b1; mode = 3'd5; par_in = 8'h5A;
    tick();
    enable = 1'b0; start = 1'b1; par_in = 8'hC3;
    start4 = 1'b1; par_in4 = 4'h9;
    tick();
    start = 1'b0; start4 = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (reg_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
      bad++;
      $display("FAIL reset8 got reg=%h busy=%b done=%b ser=%b want 00/0/0/0", reg_out, busy, done, ser_out);
    end
    total++;
    if (reg_out4 !== 4'h0 || busy4 !== 1'b0 || done4 !== 1'b0 || ser_out4 !== 1'b0) begin
      bad++;
      $display("FAIL reset4 got reg=%h busy=%b done=%b ser=%b want 0/0/0/0", reg_out4, busy4, done4, ser_out4);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_modes();
    logic [2:0] dm[6] = '{3'd5, 3'd1, 3'd4, 3'd3, 3'd2, 3'd7};
    logic       ds[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] dw[6] = '{8'h81, 8'h02, 8'h01, 8'h02, 8'h81, 8'h00};
    logic [7:0] exp_r;
    for (int i = 0; i < 6; i++) begin
      enable = 1'b1; mode = dm[i]; ser_in = ds[i]; par_in = 8'h81;
      tick();
      total++;
      if (reg_out !== dw[i]) begin
        bad++;
        $display("FAIL mode_dir step=%0d mode=%0d got=%h want=%h", i, dm[i], reg_out, dw[i]);
      end
    end
    exp_r = reg_out;
    for (int i = 0; i < 60; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      mode   = 3'($urandom_range(0, 7));
      ser_in = 1'($urandom);
      par_in = 8'($urandom);
      if (enable) exp_r = model_op(exp_r, mode, ser_in, par_in);
      tick();
      total++;
      if (reg_out !== exp_r || busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL mode_rnd i=%0d en=%b mode=%0d got=%h busy=%b done=%b want=%h",
                 i, enable, mode, reg_out, busy, done, exp_r);
      end
    end
    enable = 1'b0;
  endtask

  // One 8-bit MSB-first burst; optional enable stall before shift stall_at
  task automatic run_burst8(input logic [7:0] p, input logic [7:0] fill,
                            input int stall_at, input int stall_len,
                            input logic [2:0] start_mode, input logic start_en);
    logic [7:0] exp_final;
    logic [7:0] held;
    int busy_cycles;
    for (int k = 0; k < 8; k++) exp_final[7-k] = fill[k];
    busy_cycles = 0;
    start = 1'b1; par_in = p; mode = start_mode; enable = start_en;
    tick();
    start = 1'b0; par_in = 8'($urandom);
    total++;
    if (reg_out !== p || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL burst_load got reg=%h busy=%b done=%b want reg=%h busy=1 done=0", reg_out, busy, done, p);
    end
    for (int k = 0; k < 8; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          held = reg_out;
          if (busy === 1'b1) busy_cycles++;
          enable = 1'b0; start = 1'($urandom); mode = 3'($urandom);
          tick();
          total++;
          if (reg_out !== held || busy !== 1'b1) begin
            bad++;
            $display("FAIL burst_stall k=%0d got reg=%h busy=%b want reg=%h busy=1", k, reg_out, busy, held);
          end
        end
      end
      total++;
      if (ser_out !== p[7-k] || busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL burst_ser k=%0d got ser=%b busy=%b done=%b want ser=%b busy=1 done=0",
                 k, ser_out, busy, done, p[7-k]);
      end
      if (busy === 1'b1) busy_cycles++;
      enable = 1'b1; ser_in = fill[k]; start = 1'($urandom); mode = 3'($urandom);
      tick();
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || reg_out !== exp_final) begin
      bad++;
      $display("FAIL burst_done got done=%b busy=%b reg=%h want done=1 busy=0 reg=%h", done, busy, reg_out, exp_final);
    end
    total++;
    if (busy_cycles !== 8 + stall_len) begin
      bad++;
      $display("FAIL burst_busy_len got=%0d want=%0d", busy_cycles, 8 + stall_len);
    end
    start = 1'b1; mode = 3'd5; enable = 1'b1; par_in = ~exp_final;
    tick();
    start = 1'b0; enable = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || reg_out !== exp_final) begin
      bad++;
      $display("FAIL burst_after_done got done=%b busy=%b reg=%h want 0/0/%h", done, busy, reg_out, exp_final);
    end
  endtask

  task automatic test_burst();
    run_burst8(8'hA5, 8'h00, -1, 0, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) run_burst8(8'($urandom), 8'($urandom), -1, 0, 3'($urandom), 1'($urandom));
  endtask

  task automatic test_stall();
    run_burst8(8'hA5, 8'h00, 4, 3, 3'd0, 1'b1);
    run_burst8(8'($urandom), 8'($urandom), 1, 2, 3'd0, 1'b1);
  endtask

  task automatic test_interlock();
    run_burst8(8'h3C, 8'($urandom), -1, 0, 3'd5, 1'b1);
    run_burst8(8'hE1, 8'($urandom), 6, 1, 3'd7, 1'b0);
  endtask

  task automatic test_lsb_first();
    logic [3:0] p;
    logic [3:0] fill;
    for (int n = 0; n < 3; n++) begin
      p = (n == 0) ? 4'hB : 4'($urandom);
      fill = 4'($urandom);
      start4 = 1'b1; par_in4 = p; enable4 = 1'b1;
      tick();
      start4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
        total++;
        if (ser_out4 !== p[k] || busy4 !== 1'b1) begin
          bad++;
          $display("FAIL lsb_ser n=%0d k=%0d got ser=%b busy=%b want ser=%b busy=1", n, k, ser_out4, busy4, p[k]);
        end
        ser_in4 = fill[k];
        tick();
      end
      total++;
      if (done4 !== 1'b1 || reg_out4 !== fill) begin
        bad++;
        $display("FAIL lsb_done n=%0d got done=%b reg=%h want done=1 reg=%h", n, done4, reg_out4, fill);
      end
      tick();
    end
    enable4 = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int done_seen;
    start4 = 1'b1; par_in4 = 4'hB; enable4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || reg_out4 !== 4'h0) begin
      bad++;
      $display("FAIL midburst_reset got busy=%b done=%b reg=%h want 0/0/0", busy4, done4, reg_out4);
    end
    #2 reset_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done4 !== 1'b0 || busy4 !== 1'b0) done_seen++;
    end
    total++;
    if (done_seen !== 0) begin
      bad++;
      $display("FAIL midburst_no_done got active_cycles=%0d want=0", done_seen);
    end
    enable4 = 1'b0;
  endtask

  initial begin
    #3;
    test_reset();
    test_modes();
    test_burst();
    test_stall();
    test_interlock();
    test_lsb_first();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
